// File: rtl/prog_prediv.sv
// Programmable CKV prescaler: divides by 2..2^CW-1 with a near-50% duty CKVCNT,
// a terminal-count strobe, glitch-free ratio updates and a phase realign input.
module prog_prediv #(
  parameter int unsigned CW      = 8,
  parameter int unsigned DIV_RST = 2
) (
  input  logic          ckv,
  input  logic          rstn,
  input  logic [CW-1:0] divn,
  input  logic          div_load,
  input  logic          sync,
  output logic          ckd2,
  output logic          ckvcnt,
  output logic          tc,
  output logic          busy
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] n_act;
  logic [CW-1:0] n_pend;
  logic [CW-1:0] half;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] divn_clamped;
  logic          wrap;
  logic          restart;

  assign half         = n_act >> 1;
  assign cnt_inc      = cnt + CW'(1);
  assign divn_clamped = (divn < CW'(2)) ? CW'(2) : divn;
  assign wrap         = (cnt == n_act - CW'(1));
  assign restart      = sync | wrap;

  // Fixed divide-by-2, independent of ratio and realign activity
  always_ff @(posedge ckv or negedge rstn) begin
    if (!rstn) begin
      ckd2 <= 1'b0;
    end else begin
      ckd2 <= ~ckd2;
    end
  end

  // Period counter; the active ratio only moves at a period boundary so no
  // CKVCNT phase is ever cut short. A same-edge load stays pending.
  always_ff @(posedge ckv or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      n_act  <= CW'(DIV_RST);
      n_pend <= CW'(DIV_RST);
      ckvcnt <= 1'b0;
      tc     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      if (restart) begin
        cnt    <= '0;
        ckvcnt <= 1'b1;
        tc     <= ~sync;
        if (busy) begin
          n_act <= n_pend;
        end
      end else begin
        cnt <= cnt_inc;
        tc  <= 1'b0;
        if (cnt_inc == half) begin
          ckvcnt <= 1'b0;
        end
      end

      if (div_load) begin
        n_pend <= divn_clamped;
        busy   <= 1'b1;
      end else if (restart) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
